dbus_sram_resp: RTL and testbench

Responder end of the data-bus request/response protocol. It sits on the memory side of the core's `dreq`/`dresp` pair and stands in for data memory in simulation and small FPGA builds. It accepts one held request at a time and performs byte-strobed writes or full-word reads on an internal 64-bit-wide SRAM array. It returns a single-cycle `data_ok` pulse after a programmable latency, and it flags misaligned or out-of-range accesses.

---
 rtl/dbus_sram_resp_if.sv | 36 +++
 rtl/dbus_sram_resp.sv | 105 ++++++++++
 tb/tb_dbus_sram_resp.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_resp_if.sv
// Data-bus request/response types and the bundle carried between
// the core's data port and the memory responder.
package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

interface dbus_sram_resp_if;
  import dbus_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_resp.sv
// SRAM-backed data-bus responder: one held request at a time,
// byte-strobed writes, full-word reads, fixed response latency.
module dbus_sram_resp #(
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          DEPTH   = 65536,
  parameter int          LATENCY = 1
) (
  input  logic           clk,
  input  logic           reset,
  dbus_sram_resp_if.slave bus,
  output logic [15:0]    err_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [63:0]   rdata;
  logic [63:0]   mem [DEPTH];

  logic [63:0]   off;
  logic [2:0]    sz;
  logic [2:0]    amask;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          ok;
  logic          acc;
  logic          wr;

  always_comb begin
    off      = bus.dreq.addr - BASE;
    idx      = off[AW+2:3];
    sz       = bus.dreq.size;
    in_range = (bus.dreq.addr >= BASE)
             && ((off >> (AW + 3)) == 64'd0);
    amask    = 3'b111;
    unique case (sz)
      3'd0:    amask = 3'b000;
      3'd1:    amask = 3'b001;
      3'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    aligned  = (bus.dreq.addr[2:0] & amask) == 3'b000;
    ok       = in_range && aligned;
    acc      = (state == S_IDLE) && bus.dreq.valid;
    wr       = |bus.dreq.strobe;
  end

  // Array is deliberately left out of reset; contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && acc && ok && wr) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.dreq.strobe[i])
          mem[idx][8*i +: 8] <= bus.dreq.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata   <= 64'd0;
      err_cnt <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.dreq.valid) begin
            if (!ok) begin
              rdata <= 64'd0;
              if (err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
            end else if (!wr) begin
              rdata <= mem[idx];
            end
            cnt   <= LAT_M1;
            state <= (LATENCY == 1) ? S_RESP : S_BUSY;
          end
        end
        S_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.dresp         = '0;
    bus.dresp.addr_ok = acc;
    bus.dresp.data_ok = (state == S_RESP);
    bus.dresp.data    = rdata;
  end

endmodule

// File: tb/tb_dbus_sram_resp.sv
// Directed bench for dbus_sram_resp: three instances with
// latencies 1, 4 and 3 exercised through their own buses.
module tb_dbus_sram_resp;
  import dbus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, rst2;
  logic [15:0] e0, e1, e2;
  dbus_req_t rq [3];

  int n_chk = 0;
  int n_err = 0;

  dbus_sram_resp_if b0 ();
  dbus_sram_resp_if b1 ();
  dbus_sram_resp_if b2 ();

  assign b0.dreq = rq[0];
  assign b1.dreq = rq[1];
  assign b2.dreq = rq[2];

  dbus_sram_resp #(.DEPTH(64), .LATENCY(1)) u0 (
    .clk(clk), .reset(rst0), .bus(b0.slave), .err_cnt(e0));
  dbus_sram_resp #(.DEPTH(64), .LATENCY(4)) u1 (
    .clk(clk), .reset(rst1), .bus(b1.slave), .err_cnt(e1));
  dbus_sram_resp #(.DEPTH(64), .LATENCY(3)) u2 (
    .clk(clk), .reset(rst2), .bus(b2.slave), .err_cnt(e2));

  function automatic dbus_resp_t rs(input int s);
    case (s)
      0:       return b0.dresp;
      1:       return b1.dresp;
      default: return b2.dresp;
    endcase
  endfunction

  function automatic logic [15:0] ec(input int s);
    case (s)
      0:       return e0;
      1:       return e1;
      default: return e2;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input int s, input int lat,
                     input logic [63:0] a, input msize_t sz,
                     input logic [7:0] st, input logic [63:0] d,
                     input logic [63:0] exp, input bit cd);
    @(negedge clk);
    rq[s] = '{valid: 1'b1, addr: a, size: sz,
              strobe: st, data: d};
    #1;
    chk("addr_ok", 64'(rs(s).addr_ok), 64'd1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      if (k < lat) begin
        chk("busy_data_ok", 64'(rs(s).data_ok), 64'd0);
      end else begin
        chk("data_ok", 64'(rs(s).data_ok), 64'd1);
        if (cd) chk("rdata", rs(s).data, exp);
        rq[s].valid = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rq[i] = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("rst_data_ok", 64'(rs(s).data_ok), 64'd0);
      chk("rst_addr_ok", 64'(rs(s).addr_ok), 64'd0);
      chk("rst_data", rs(s).data, 64'd0);
      chk("rst_err_cnt", 64'(ec(s)), 64'd0);
    end

    // LATENCY=1: write then read back
    txn(0, 1, 64'h8000_0010, MSIZE8, 8'hFF,
        64'h1122334455667788, 64'd0, 1'b0);
    txn(0, 1, 64'h8000_0010, MSIZE8, 8'h00, 64'd0,
        64'h1122334455667788, 1'b1);

    // partial strobe over a cleared word
    txn(0, 1, 64'h8000_0010, MSIZE8, 8'hFF, 64'd0,
        64'd0, 1'b0);
    txn(0, 1, 64'h8000_0014, MSIZE4, 8'hF0,
        64'hDEADBEEF_00000000, 64'd0, 1'b0);
    txn(0, 1, 64'h8000_0010, MSIZE8, 8'h00, 64'd0,
        64'hDEADBEEF_00000000, 1'b1);

    // errors: out of range, misaligned, one past the end
    txn(0, 1, 64'h8000_0000, MSIZE8, 8'hFF,
        64'hCAFEF00D_12345678, 64'd0, 1'b0);
    txn(0, 1, 64'h1000_0000, MSIZE8, 8'h00, 64'd0,
        64'd0, 1'b1);
    chk("err_cnt_oor", 64'(e0), 64'd1);
    txn(0, 1, 64'h8000_0003, MSIZE4, 8'h0F,
        64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    chk("err_cnt_mis", 64'(e0), 64'd2);
    txn(0, 1, 64'h8000_0000, MSIZE8, 8'h00, 64'd0,
        64'hCAFEF00D_12345678, 1'b1);
    txn(0, 1, 64'h8000_0200, MSIZE8, 8'h00, 64'd0,
        64'd0, 1'b1);
    chk("err_cnt_end", 64'(e0), 64'd3);
    txn(0, 1, 64'h8000_01F8, MSIZE8, 8'hFF,
        64'hA5A5_5A5A_0F0F_F0F0, 64'd0, 1'b0);
    txn(0, 1, 64'h8000_01F8, MSIZE8, 8'h00, 64'd0,
        64'hA5A5_5A5A_0F0F_F0F0, 1'b1);
    chk("err_cnt_last", 64'(e0), 64'd3);

    // LATENCY=4: held read, pacing of addr_ok/data_ok
    txn(1, 4, 64'h8000_0008, MSIZE8, 8'hFF,
        64'h0123456789ABCDEF, 64'd0, 1'b0);
    @(negedge clk);
    rq[1] = '{valid: 1'b1, addr: 64'h8000_0008,
              size: MSIZE8, strobe: 8'h00, data: 64'd0};
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("lat_addr_ok_c%0d", c),
          64'(b1.dresp.addr_ok), (c == 0 || c == 5) ? 64'd1 : 64'd0);
      if (c >= 1 && c <= 4)
        chk($sformatf("lat_data_ok_c%0d", c),
            64'(b1.dresp.data_ok), (c == 4) ? 64'd1 : 64'd0);
      if (c == 4)
        chk("lat_rdata", b1.dresp.data, 64'h0123456789ABCDEF);
    end
    rq[1].valid = 1'b0;

    // LATENCY=4: reset asserted mid-BUSY
    @(negedge clk);
    rq[1] = '{valid: 1'b1, addr: 64'h8000_0008,
              size: MSIZE8, strobe: 8'h00, data: 64'd0};
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("rst_busy_data_ok", 64'(b1.dresp.data_ok), 64'd0);
    chk("rst_busy_state", 64'(u1.state), 64'd0);
    chk("rst_busy_addr_ok", 64'(b1.dresp.addr_ok), 64'd1);
    @(negedge clk);
    #1;
    chk("rst_hold_data_ok", 64'(b1.dresp.data_ok), 64'd0);
    rst1 = 1'b0;
    #1;
    chk("post_rst_addr_ok", 64'(b1.dresp.addr_ok), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst_data_ok_k%0d", k),
          64'(b1.dresp.data_ok), (k == 4) ? 64'd1 : 64'd0);
      if (k == 4)
        chk("post_rst_rdata", b1.dresp.data, 64'h0123456789ABCDEF);
    end
    rq[1].valid = 1'b0;
    chk("err_cnt_u1", 64'(e1), 64'd0);

    // LATENCY=3: valid dropped right after acceptance
    @(negedge clk);
    rq[2] = '{valid: 1'b1, addr: 64'h8000_0020,
              size: MSIZE8, strobe: 8'hFF,
              data: 64'h5555AAAA_3333CCCC};
    @(negedge clk);
    rq[2].valid = 1'b0;
    #1;
    chk("drop_addr_ok_c1", 64'(b2.dresp.addr_ok), 64'd0);
    chk("drop_data_ok_c1", 64'(b2.dresp.data_ok), 64'd0);
    @(negedge clk);
    #1;
    chk("drop_data_ok_c2", 64'(b2.dresp.data_ok), 64'd0);
    @(negedge clk);
    #1;
    chk("drop_data_ok_c3", 64'(b2.dresp.data_ok), 64'd1);
    txn(2, 3, 64'h8000_0020, MSIZE8, 8'h00, 64'd0,
        64'h5555AAAA_3333CCCC, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
